// File: rtl/alu_operand_entry_if.sv
// Command bus from the operand entry stage to the ALU: fields plus valid/ready.
interface alu_operand_entry_if #(
  parameter int WIDTH = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             cin;

  modport master (output out_valid, a, b, op, cin, input out_ready);
  modport slave  (input out_valid, a, b, op, cin, output out_ready);
endinterface

// File: rtl/alu_operand_entry.sv
// Operand/command entry stage ahead of the ALU: key conditioning, entry FSM, valid/ready issue.
// Optional per-key debounce filter enabled by defining ALU_DEBOUNCE_EN.

module alu_key_cond #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic ev_o
);
  logic sync1_q, sync2_q, prev_q, lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef ALU_DEBOUNCE_EN
  logic       filt_q;
  logic [7:0] cnt_q;

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (sync2_q == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
      filt_q <= sync2_q;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= lvl;
  end

  assign ev_o = lvl & ~prev_q;
endmodule

module alu_operand_entry #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  hz100,
  input  logic                  reset,
  input  logic [15:0]           digit_pb,
  input  logic                  next_pb,
  input  logic                  clear_pb,
  input  logic                  cin_pb,
  alu_operand_entry_if.master   cmd,
  output logic [1:0]            state,
  output logic                  err
);
  localparam int NKEYS = 19;

  typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_OP = 2'b10, S_ISSUE = 2'b11} st_e;

  logic [NKEYS-1:0] keys, ev;
  logic [15:0]      dig_ev;
  logic             nxt_ev, clr_ev, cin_ev;

  assign keys = {cin_pb, clear_pb, next_pb, digit_pb};

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    alu_key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk  (hz100),
      .rst_n(reset),
      .key_i(keys[k]),
      .ev_o (ev[k])
    );
  end

  assign dig_ev = ev[15:0];
  assign nxt_ev = ev[16];
  assign clr_ev = ev[17];
  assign cin_ev = ev[18];

  st_e              state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             cin_q, cin_d, vld_q, vld_d, err_q, err_d;
  logic [3:0]       dsel;

  // Lowest-index digit wins when several edge in the same cycle.
  always_comb begin
    dsel = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (dig_ev[i]) dsel = 4'(i);
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cin_d   = cin_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    if (clr_ev) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      cin_d   = 1'b0;
      vld_d   = 1'b0;
    end else if (state_q == S_ISSUE) begin
      // Keys other than clear are ignored while the command waits for acceptance.
      if (cmd.out_ready) begin
        state_d = S_A;
        vld_d   = 1'b0;
      end
    end else if (nxt_ev) begin
      case (state_q)
        S_A:     state_d = S_B;
        S_B:     state_d = S_OP;
        default: begin
          state_d = S_ISSUE;
          vld_d   = 1'b1;
        end
      endcase
    end else if (cin_ev) begin
      cin_d = ~cin_q;
    end else if (|dig_ev) begin
      case (state_q)
        S_A:     a_d = (a_q << 4) | WIDTH'(dsel);
        S_B:     b_d = (b_q << 4) | WIDTH'(dsel);
        default: begin
          if (!dsel[3]) op_d  = dsel[2:0];
          else          err_d = 1'b1;
        end
      endcase
    end
  end

  assign cmd.out_valid = vld_q;
  assign cmd.a         = a_q;
  assign cmd.b         = b_q;
  assign cmd.op        = op_q;
  assign cmd.cin       = cin_q;
  assign state         = state_q;
  assign err           = err_q;
endmodule
